// File: rtl/seg7_pkg.sv
// Shared seven-segment glyphs and digit helpers.
// Segment order is {g,f,e,d,c,b,a}, 1 = lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

  // Digits outside the radix load as the largest legal digit.
  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d,
    input int         m
  );
    logic [3:0] r;
    r = d;
    if (int'(d) >= m) r = 4'(m - 1);
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_multidigit_counter_if.sv
// Control and display bundle for one display bank.
// slave = counter side, master = board/controller side.
interface seven_segment_multidigit_counter_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [7:0]              tick_sel;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    tick;
  logic                    wrap;

  modport master (
    output en,
    output up_dn,
    output load,
    output load_val,
    output tick_sel,
    input  seg_out,
    input  dp_out,
    input  dig_sel,
    input  value,
    input  tick,
    input  wrap
  );

  modport slave (
    input  en,
    input  up_dn,
    input  load,
    input  load_val,
    input  tick_sel,
    output seg_out,
    output dp_out,
    output dig_sel,
    output value,
    output tick,
    output wrap
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One radix-MODULUS counter digit.
// Carry ripples combinationally to the next cell.
module bcd_digit_cell
  import seg7_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       step,
  input  logic       up_dn,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out
);

  localparam logic [3:0] TOP = 4'(MODULUS - 1);

  logic       at_end;
  logic [3:0] nxt;

  assign at_end    = up_dn ? (q == TOP) : (q == 4'd0);
  assign carry_out = carry_in & at_end;

  // Next digit in the current direction, rolling at the radix ends
  always_comb begin
    nxt = q;
    if (up_dn) begin
      nxt = at_end ? 4'd0 : q + 4'd1;
    end else begin
      nxt = at_end ? TOP : q - 4'd1;
    end
  end

  // Digit register: load beats a step
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= clamp_digit(load_d, MODULUS);
    end else if (step && carry_in) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/seven_segment_multidigit_counter.sv
// Multi-digit up/down counter with scanned seven-segment drive.
// Holds prescaler, digit chain, scan and output registers.
module seven_segment_multidigit_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_COUNT   = 10_000_000,
  parameter int TICK_W       = 24,
  parameter int SCAN_COUNT   = 10_000,
  parameter int SCAN_W       = 14,
  parameter int MODULUS      = 10,
  parameter int COMMON_ANODE = 0
) (
  input logic clk,
  input logic reset,
  seven_segment_multidigit_counter_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ?
                         $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_TERM =
    TICK_W'(TICK_COUNT);
  localparam logic [SCAN_W-1:0] SCAN_TERM =
    SCAN_W'(SCAN_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (COMMON_ANODE != 0);

  logic [TICK_W-1:0]       pre;
  logic [TICK_W-1:0]       cmp;
  logic                    tick_q;
  logic                    wrap_q;
  logic                    step;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS:0]     carry;
  logic [3:0]              digs [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] val;

  // A non-zero tick_sel selects a coarse 1024-clock-granular rate
  assign cmp = (bus.tick_sel == 8'd0) ?
               TICK_TERM :
               TICK_W'({bus.tick_sel, 10'b0});

  // A load on a tick cycle swallows that tick
  assign step     = tick_q & ~bus.load;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_cell #(
      .MODULUS(MODULUS)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .load_d    (bus.load_val[4*i +: 4]),
      .step      (step),
      .up_dn     (bus.up_dn),
      .carry_in  (carry[i]),
      .q         (digs[i]),
      .carry_out (carry[i+1])
    );
    assign val[4*i +: 4] = digs[i];
  end

  // Prescaler: counts to compare, then one-cycle tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else if (bus.load) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else if (bus.en) begin
      if (pre == cmp) begin
        pre    <= '0;
        tick_q <= 1'b1;
      end else begin
        pre    <= pre + TICK_W'(1);
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // Wrap fires with the step that carries out of the top digit
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step & carry[NUM_DIGITS];
    end
  end

  // Free-running digit scan
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_TERM) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ?
                  '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Segment register, polarity folded in here
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK ^ {7{POL}};
    end else begin
      seg_q <= seg7_decode(digs[scan_idx]) ^ {7{POL}};
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.dig_sel = (NUM_DIGITS'(1) << scan_idx) ^
                       {NUM_DIGITS{POL}};
  assign bus.dp_out  = ((scan_idx == '0) & ~bus.en) ^ POL;
  assign bus.value   = val;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_seven_segment_multidigit_counter.sv
// Bench: BCD/common-cathode and hex/common-anode banks
// driven together, checked against an integer-count model.
module tb_seven_segment_multidigit_counter;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [7:0]  tick_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_segment_multidigit_counter_if #(.NUM_DIGITS(ND)) b10 ();
  seven_segment_multidigit_counter_if #(.NUM_DIGITS(ND)) b16 ();

  assign b10.en       = en;
  assign b10.up_dn    = up_dn;
  assign b10.load     = load;
  assign b10.load_val = load_val;
  assign b10.tick_sel = tick_sel;
  assign b16.en       = en;
  assign b16.up_dn    = up_dn;
  assign b16.load     = load;
  assign b16.load_val = load_val;
  assign b16.tick_sel = tick_sel;

  seven_segment_multidigit_counter #(
    .NUM_DIGITS(ND), .TICK_COUNT(4), .TICK_W(24),
    .SCAN_COUNT(3), .SCAN_W(14),
    .MODULUS(10), .COMMON_ANODE(0)
  ) dut10 (
    .clk(clk), .reset(reset), .bus(b10)
  );

  seven_segment_multidigit_counter #(
    .NUM_DIGITS(ND), .TICK_COUNT(4), .TICK_W(24),
    .SCAN_COUNT(3), .SCAN_W(14),
    .MODULUS(16), .COMMON_ANODE(1)
  ) dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );

  // model state: count as a plain integer per bank
  int         mmod [2] = '{10, 16};
  bit         mca  [2] = '{1'b0, 1'b1};
  int         mv   [2] = '{0, 0};
  bit         mwrap[2] = '{1'b0, 1'b0};
  logic [6:0] mseg [2] = '{7'd0, 7'd0};
  int         mpre  = 0;
  bit         mtick = 1'b0;
  int         mscnt = 0;
  int         msidx = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g;
    case (d)
      0:  g = 7'b0111111;
      1:  g = 7'b0000110;
      2:  g = 7'b1011011;
      3:  g = 7'b1001111;
      4:  g = 7'b1100110;
      5:  g = 7'b1101101;
      6:  g = 7'b1111101;
      7:  g = 7'b0000111;
      8:  g = 7'b1111111;
      9:  g = 7'b1101111;
      10: g = 7'b1110111;
      11: g = 7'b1111100;
      12: g = 7'b0111001;
      13: g = 7'b1011110;
      14: g = 7'b1111001;
      15: g = 7'b1110001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  function automatic int span(input int m);
    return m * m * m * m;
  endfunction

  function automatic int digit_of(input int v, input int m,
                                  input int idx);
    int x;
    x = v;
    for (int i = 0; i < idx; i++) x = x / m;
    return x % m;
  endfunction

  function automatic logic [15:0] to_digits(input int v,
                                            input int m);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % m);
      x = x / m;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv,
                                   input int m);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > m - 1) d = m - 1;
      r = r + d * p;
      p = p * m;
    end
    return r;
  endfunction

  task automatic model_edge();
    int cmp;
    cmp = (tick_sel == 8'd0) ? 4 : int'(tick_sel) * 1024;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mv[k]    = 0;
        mwrap[k] = 1'b0;
        mseg[k]  = 7'd0;
      end
      mpre  = 0;
      mtick = 1'b0;
      mscnt = 0;
      msidx = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        mseg[k]  = glyph(digit_of(mv[k], mmod[k], msidx));
        mwrap[k] = 1'b0;
        if (load) begin
          mv[k] = from_load(load_val, mmod[k]);
        end else if (mtick) begin
          if (up_dn) begin
            mwrap[k] = (mv[k] == span(mmod[k]) - 1);
            mv[k]    = (mv[k] + 1) % span(mmod[k]);
          end else begin
            mwrap[k] = (mv[k] == 0);
            mv[k] = (mv[k] + span(mmod[k]) - 1) % span(mmod[k]);
          end
        end
      end
      if (load) begin
        mpre  = 0;
        mtick = 1'b0;
      end else if (en) begin
        mtick = (mpre == cmp);
        mpre  = mtick ? 0 : mpre + 1;
      end else begin
        mtick = 1'b0;
      end
      if (mscnt == 2) begin
        mscnt = 0;
        msidx = (msidx == ND - 1) ? 0 : msidx + 1;
      end else begin
        mscnt++;
      end
    end
  endtask

  task automatic check_dut(input int k,
                           input logic [15:0] v,
                           input logic t,
                           input logic w,
                           input logic [6:0] s,
                           input logic [3:0] d,
                           input logic p);
    logic [6:0] es;
    logic [3:0] ed;
    logic       ep;
    string      b;
    b  = $sformatf("m%0d", mmod[k]);
    es = mseg[k];
    ed = 4'b0001 << msidx;
    ep = (msidx == 0) && !en;
    if (mca[k]) begin
      es = ~es;
      ed = ~ed;
      ep = ~ep;
    end
    chk({b, "_value"}, 32'(v), 32'(to_digits(mv[k], mmod[k])));
    chk({b, "_tick"},  32'(t), 32'(mtick));
    chk({b, "_wrap"},  32'(w), 32'(mwrap[k]));
    chk({b, "_seg"},   32'(s), 32'(es));
    chk({b, "_dig"},   32'(d), 32'(ed));
    chk({b, "_dp"},    32'(p), 32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_dut(0, b10.value, b10.tick, b10.wrap,
              b10.seg_out, b10.dig_sel, b10.dp_out);
    check_dut(1, b16.value, b16.tick, b16.wrap,
              b16.seg_out, b16.dig_sel, b16.dp_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_now(input logic [15:0] lv);
    load     = 1'b1;
    load_val = lv;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (b10.tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wait_tick", 32'(b10.tick), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    tick_sel = '0;
    run(2);
    reset = 1'b0;
    en    = 1'b1;
    run(12);

    load_now(16'h0999);
    run(6);
    load_now(16'h9999);
    run(6);
    up_dn = 1'b0;
    load_now(16'h0000);
    run(6);
    up_dn = 1'b1;
    load_now(16'hFFFF);
    run(6);

    wait_tick();
    load_now(16'h12C4);
    run(3);

    load_now(16'h0042);
    run(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(3);

    en = 1'b0;
    run(15);
    en = 1'b1;

    tick_sel = 8'd1;
    load_now(16'h0123);
    run(1030);
    tick_sel = 8'd0;
    load_now(16'h0500);
    run(4);

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
      load  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 16'h9999;
        1:       load_val = 16'hFFFF;
        2:       load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      step();
    end
    reset = 1'b0;
    load  = 1'b0;
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
